// File: rtl/sw_access_arb.sv
// Round-robin arbiter sharing one software access path between N_MST requesters.
// Each granted request becomes one single-cycle sw_wr/sw_rd strobe followed by one ack pulse.
module sw_access_arb #(
  parameter int N_MST  = 2,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        mst_req,
  input  logic [N_MST-1:0]        mst_wr,
  input  logic [N_MST*DATA_W-1:0] mst_wdata,
  output logic [N_MST-1:0]        mst_ack,
  output logic [DATA_W-1:0]       mst_rdata,
  output logic [N_MST-1:0]        sw_wr,
  output logic [N_MST-1:0]        sw_rd,
  output logic [N_MST*DATA_W-1:0] sw_wr_data,
  input  logic [DATA_W-1:0]       field_rd_data,
  output logic                    busy
);

  // state | meaning
  // IDLE  | no transaction, arbitrating mst_req
  // ISSUE | one-cycle strobe to the datapath
  // WAIT  | read latency countdown
  // RESP  | one-cycle ack to the granted requester
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int CNT_W = 3;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_sel;
  logic               gnt_vld;
  logic               dir_wr;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   cnt;
  int unsigned        idx;

  // Scan downward so the smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = '0;
    idx     = 0;
    for (int k = N_MST - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_MST;
      if (mst_req[idx]) begin
        gnt_vld = 1'b1;
        gnt_sel = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      dir_wr  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            gnt     <= gnt_sel;
            dir_wr  <= mst_wr[gnt_sel];
            wdata_q <= mst_wdata[int'(gnt_sel)*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          if (!dir_wr) begin
            cnt <= CNT_W'(RD_LAT - 1);
            if (RD_LAT == 1) rdata_q <= field_rd_data;
          end
        end
        WAIT: begin
          // cnt == 1 is the cycle the countdown reaches zero
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) rdata_q <= field_rd_data;
        end
        RESP: begin
          ptr <= (gnt == IDX_W'(N_MST - 1)) ? '0 : gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    mst_ack    = '0;
    mst_rdata  = '0;
    sw_wr      = '0;
    sw_rd      = '0;
    sw_wr_data = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (gnt_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (dir_wr) begin
          sw_wr[gnt] = 1'b1;
          sw_wr_data[int'(gnt)*DATA_W +: DATA_W] = wdata_q;
          state_nxt = RESP;
        end else begin
          sw_rd[gnt] = 1'b1;
          state_nxt  = (RD_LAT > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        mst_ack[gnt] = 1'b1;
        if (!dir_wr) mst_rdata = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sw_access_arb.sv
// Directed bench for sw_access_arb with N_MST=2, DATA_W=32, RD_LAT=3.
module tb_sw_access_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mst_req;
  logic [1:0]  mst_wr;
  logic [63:0] mst_wdata;
  logic [1:0]  mst_ack;
  logic [31:0] mst_rdata;
  logic [1:0]  sw_wr;
  logic [1:0]  sw_rd;
  logic [63:0] sw_wr_data;
  logic [31:0] field_rd_data;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int viol = 0;
  int wr_pulses = 0;

  sw_access_arb #(.N_MST(2), .DATA_W(32), .RD_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .mst_req(mst_req), .mst_wr(mst_wr), .mst_wdata(mst_wdata),
    .mst_ack(mst_ack), .mst_rdata(mst_rdata),
    .sw_wr(sw_wr), .sw_rd(sw_rd), .sw_wr_data(sw_wr_data),
    .field_rd_data(field_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // strobes and acks must never overlap or be more than one-hot
  always @(negedge clk) begin
    if (!rst) begin
      if ((sw_wr != 0 && sw_rd != 0) || $countones(sw_wr) > 1 ||
          $countones(sw_rd) > 1 || $countones(mst_ack) > 1)
        viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    if (sw_wr != 0) wr_pulses++;
  endtask

  logic [31:0] d6 [4];

  initial begin
    d6[0] = 32'h1111_0001; d6[1] = 32'h2222_0002;
    d6[2] = 32'h3333_0003; d6[3] = 32'h4444_0004;
    rst = 1'b1; mst_req = '0; mst_wr = '0; mst_wdata = '0; field_rd_data = '0;
    repeat (3) nxt();
    chk("rst_busy", busy, 0);
    chk("rst_ack", mst_ack, 0);
    chk("rst_swwr", sw_wr, 0);
    chk("rst_swrd", sw_rd, 0);
    chk("rst_wdata", sw_wr_data, 0);
    chk("rst_rdata", mst_rdata, 0);

    // single write from master0
    rst = 1'b0;
    mst_req = 2'b01; mst_wr = 2'b01; mst_wdata = {32'h0, 32'hA5A5_0001};
    chk("wr_t_busy", busy, 0);
    nxt();
    chk("wr_strobe", sw_wr, 2'b01);
    chk("wr_data", sw_wr_data, {32'h0, 32'hA5A5_0001});
    chk("wr_no_rd", sw_rd, 0);
    chk("wr_busy1", busy, 1);
    chk("wr_no_early_ack", mst_ack, 0);
    nxt();
    chk("wr_ack", mst_ack, 2'b01);
    chk("wr_rdata0", mst_rdata, 0);
    chk("wr_busy2", busy, 1);
    chk("wr_strobe_off", sw_wr, 0);
    mst_req = 2'b00;
    nxt();
    chk("wr_idle", busy, 0);
    chk("wr_ack_off", mst_ack, 0);

    // read from master1, RD_LAT=3
    mst_req = 2'b10; mst_wr = 2'b00;
    nxt();
    chk("rd_strobe", sw_rd, 2'b10);
    chk("rd_no_wr", sw_wr, 0);
    field_rd_data = 32'h1234_5678;
    nxt();
    chk("rd_strobe_once", sw_rd, 0);
    chk("rd_busy_wait", busy, 1);
    nxt();
    chk("rd_no_early_ack", mst_ack, 0);
    nxt();
    chk("rd_ack", mst_ack, 2'b10);
    chk("rd_rdata", mst_rdata, 32'h1234_5678);
    mst_req = 2'b00;
    nxt();
    field_rd_data = '0;
    chk("rd_idle", busy, 0);

    // contention: both masters write continuously, grants 0,1,0,1
    mst_req = 2'b11; mst_wr = 2'b11; mst_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("cont_strobe", sw_wr, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("cont_lane", sw_wr_data, (k % 2 == 0) ? {32'h0, 32'hAAAA_0000} : {32'hBBBB_0001, 32'h0});
      nxt();
      chk("cont_ack", mst_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 3) mst_req = 2'b00;
      nxt();
      chk("cont_idle_ack", mst_ack, 0);
    end

    // drop request after grant: master0 read
    mst_req = 2'b01; mst_wr = 2'b00;
    nxt();
    chk("drop_strobe", sw_rd, 2'b01);
    mst_req = 2'b00;
    field_rd_data = 32'hDEAD_BEEF;
    nxt();
    chk("drop_rd_once", sw_rd, 0);
    nxt();
    chk("drop_no_early", mst_ack, 0);
    nxt();
    chk("drop_ack", mst_ack, 2'b01);
    chk("drop_rdata", mst_rdata, 32'hDEAD_BEEF);
    nxt();
    field_rd_data = '0;
    chk("drop_idle", busy, 0);
    chk("drop_no_ack", mst_ack, 0);

    // reset during WAIT aborts with no ack and clears the pointer
    mst_req = 2'b10; mst_wr = 2'b00;
    nxt();
    chk("rstw_strobe", sw_rd, 2'b10);
    nxt();
    chk("rstw_wait", busy, 1);
    rst = 1'b1; mst_req = 2'b00;
    nxt();
    chk("rstw_busy", busy, 0);
    chk("rstw_ack", mst_ack, 0);
    chk("rstw_rd", sw_rd, 0);
    chk("rstw_rdata", mst_rdata, 0);
    rst = 1'b0;
    nxt();
    chk("rstw_no_late_ack", mst_ack, 0);
    mst_req = 2'b11; mst_wr = 2'b11; mst_wdata = {32'hC1C1_0001, 32'hC0C0_0000};
    nxt();
    chk("rstw_ptr0", sw_wr, 2'b01);
    nxt();
    chk("rstw_ack0", mst_ack, 2'b01);
    nxt();
    nxt();
    chk("rstw_m1_strobe", sw_wr, 2'b10);
    chk("rstw_m1_data", sw_wr_data[63:32], 32'hC1C1_0001);
    nxt();
    chk("rstw_m1_ack", mst_ack, 2'b10);
    mst_req = 2'b00;
    nxt();

    // back-to-back writes from master0; wdata changes after grant are ignored
    wr_pulses = 0;
    mst_req = 2'b01; mst_wr = 2'b01; mst_wdata = {32'h0, d6[0]};
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("b2b_strobe", sw_wr, 2'b01);
      mst_wdata[31:0] = 32'hBAD0_0000 | 32'(k);
      chk("b2b_data", sw_wr_data[31:0], d6[k]);
      nxt();
      chk("b2b_ack", mst_ack, 2'b01);
      if (k < 3) mst_wdata[31:0] = d6[k+1];
      else mst_req = 2'b00;
      nxt();
      chk("b2b_idle", busy, 0);
    end
    repeat (3) nxt();
    chk("b2b_pulses", wr_pulses, 4);

    chk("strobe_excl", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sw_access_arb.md
Name: sw_access_arb

Overview:
- Sequencing arbiter in front of the field/register software-access datapath.
- Shares one software access path between N_MST requesters using round-robin arbitration.
- Converts each held request into exactly one single-cycle one-hot sw_wr or sw_rd strobe.
- Returns an ack pulse and registered read data, so read side effects (RCLR/RSET) fire once per transaction.

Parameters:
- N_MST, 2, number of requesters; also the width of the sw_wr/sw_rd strobe vectors (matches the downstream SW_CNT).
- DATA_W, 32, data width per lane.
- RD_LAT, 1, cycles from the sw_rd strobe to valid field_rd_data; legal range 1..7.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mst_req  in  N_MST  per-requester request; held high until the matching mst_ack.
- mst_wr  in  N_MST  per-requester direction: 1 = write, 0 = read; stable while mst_req is high.
- mst_wdata  in  N_MST*DATA_W  per-requester write data; lane i = bits [i*DATA_W +: DATA_W].
- mst_ack  out  N_MST  one-cycle completion pulse; one-hot or zero.
- mst_rdata  out  DATA_W  read data; valid only in the cycle mst_ack is high for a read.
- sw_wr  out  N_MST  one-hot write strobe to the datapath.
- sw_rd  out  N_MST  one-hot read strobe to the datapath.
- sw_wr_data  out  N_MST*DATA_W  write data lanes; only the granted lane is driven, the others are 0.
- field_rd_data  in  DATA_W  read data from the datapath, valid RD_LAT cycles after the sw_rd strobe.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - The round-robin pointer goes to 0.
  - The latency counter goes to 0.
  - All outputs go to 0: mst_ack, mst_rdata, sw_wr, sw_rd, sw_wr_data, busy.
  - Reset asserted mid-transaction aborts it with no ack. A strobe already issued is not repeated.
- State machine: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
- IDLE:
  - If any mst_req is high, grant the first requester at or after the pointer, searching upward with wrap.
  - Latch the grant index, the direction, and that requester's wdata lane.
  - Go to ISSUE. With no requests, stay in IDLE.
- ISSUE (exactly one cycle):
  - Write: sw_wr[g] = 1 and sw_wr_data lane g = the latched wdata. Go to RESP.
  - Read: sw_rd[g] = 1. Load the counter with RD_LAT-1. Go to WAIT if RD_LAT > 1, else go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, register field_rd_data into mst_rdata and go to RESP.
  - For RD_LAT = 1, the capture happens at the end of the ISSUE cycle instead.
- RESP (one cycle):
  - mst_ack[g] = 1. mst_rdata holds the captured value for a read, 0 for a write.
  - Pointer = (g+1) mod N_MST.
  - Go to IDLE.
- Latency, measured from cycle t = first IDLE cycle with the request high:
  - Write: strobe at t+1, ack at t+2.
  - Read: strobe at t+1, ack at t+2+RD_LAT-1... i.e. ack at t+1+RD_LAT.
  - Throughput floor: one write per 3 cycles.
- Strobe rules:
  - sw_wr and sw_rd are never both nonzero.
  - At most one bit of either vector is high in any cycle.
  - Strobes are high only in ISSUE.
- Request dropped after grant:
  - The transaction completes and the ack is still pulsed. No retry.
  - The dropped request does not block others.
- A requester raising mst_req in the same cycle as its own ack is treated as a new request and arbitrated in the next IDLE cycle.
- Pointer wrap: a grant of N_MST-1 sets the pointer to 0.
- Simultaneous requests: the lowest index at or above the pointer wins. The loser keeps mst_req high and is served next without starvation; worst-case wait is N_MST-1 transactions.
- mst_wr and mst_wdata are sampled only in the granted IDLE cycle. Changes after that are ignored.

Test Plan:
- Reset, then a single write: master0 writes 0xA5A5_0001 -> sw_wr = 2'b01 and sw_wr_data[31:0] = 0xA5A5_0001 at t+1; mst_ack = 2'b01 at t+2; busy high for cycles t+1..t+2.
- Read with RD_LAT = 3: master1 reads while field_rd_data = 0x1234_5678 at t+4 -> sw_rd = 2'b10 for exactly one cycle (t+1); mst_ack[1] and mst_rdata = 0x1234_5678 at t+4.
- Contention: both masters hold writes from reset -> grants alternate 0,1,0,1; acks at cycles t+2, t+5, t+8, t+11; no strobe overlap.
- Drop request: master0 read granted, mst_req[0] deasserted at t+1 -> a single sw_rd pulse, mst_ack[0] still pulsed; an idle master1 is unaffected.
- Reset mid-WAIT (RD_LAT = 3, rst high at t+2) -> next cycle all outputs are 0, no ack, pointer back to 0; a subsequent master1 request is served normally.
- Back-to-back from one master (req held, 4 writes) -> ack every 3 cycles, exactly 4 sw_wr pulses, each carrying that write's data.
